axi_rd_rr_arbiter: RTL and testbench
====================================

Name: axi_rd_rr_arbiter

Overview:
- Two-master, one-slave AXI4 read-channel arbiter.
- Master 0 is the instruction fetch port and master 1 is the load/store read port; both share one AXI4 read path to the memory slave.
- Grants are round-robin. The grant is held for a whole burst, through the beat carrying rlast, and each burst's beat count is checked against arlen.
- A watchdog flags a stalled transaction.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 64, data width
- PRIO_M1, 0, 1 = fixed priority to master 1 instead of round-robin
- WDOG_W, 8, watchdog counter width; timeout is reached at 2^WDOG_W-1 idle cycles

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-low reset
- mN_araddr  input  ADDR_W  master N read address (N = 0, 1; one port per master)
- mN_arvalid  input  1  master N address valid
- mN_arlen  input  8  master N burst length minus 1
- mN_arsize  input  3  master N beat size
- mN_arburst  input  2  master N burst type
- mN_arready  output  1  address ready to master N
- mN_rdata  output  DATA_W  read data to master N
- mN_rresp  output  2  read response to master N
- mN_rvalid  output  1  read valid to master N
- mN_rlast  output  1  last beat to master N
- mN_rready  input  1  master N data ready
- s_araddr / s_arlen / s_arsize / s_arburst  output  ADDR_W / 8 / 3 / 2  forwarded AR fields
- s_arvalid  output  1  address valid to slave
- s_arready  input  1  slave address ready
- s_rdata / s_rresp / s_rlast  input  DATA_W / 2 / 1  slave R fields
- s_rvalid  input  1  slave read valid
- s_rready  output  1  read ready to slave
- grant  output  2  one-hot current owner; 00 when idle
- protocol_err  output  1  sticky error flag

Behaviour:
- Reset (rst=0, asynchronous) forces the following, and aborts any in-flight burst without waiting for rlast:
  - state=IDLE, grant=00, last=1 (so master 0 wins first)
  - beat_cnt=0, wdog=0, protocol_err=0
  - all mN_arready, mN_rvalid, mN_rlast, s_arvalid, s_rready = 0; all data and field outputs = 0
- IDLE:
  - If any mN_arvalid=1, register the winner and go to ADDR on the next edge. Arbitration latency is 1 cycle; no AR is forwarded while in IDLE.
  - Round-robin: if both request, the master that is not `last` wins.
  - PRIO_M1=1: master 1 always wins a tie.
- ADDR:
  - s_ar* fields and s_arvalid come combinationally from the granted master.
  - Granted mN_arready = s_arready; the ungranted arready = 0.
  - On handshake (s_arvalid & s_arready): beat_cnt <= arlen, go to DATA.
  - If the granted master drops arvalid, stay in ADDR (no re-arbitration).
- DATA:
  - Granted mN_rvalid/rdata/rresp/rlast = s_r*, and s_rready = granted mN_rready.
  - Ungranted master sees rvalid=0 and rdata=0.
  - On each beat handshake, beat_cnt decrements, saturating at 0.
  - On a handshake with s_rlast=1: last <= granted index, grant <= 00, go to IDLE. A new grant can be issued 1 cycle later.
- Beat check, on each handshake:
  - rlast=1 with beat_cnt!=0 sets protocol_err; the burst still ends on rlast.
  - rlast=0 with beat_cnt==0 also sets protocol_err.
- Watchdog:
  - In ADDR/DATA, wdog increments every cycle without a handshake on the active channel, saturating at all-ones.
  - Any handshake clears wdog; leaving to IDLE clears it.
  - Saturation sets protocol_err; the transaction is not aborted.
- protocol_err is cleared only by reset.
- A request that arrives mid-burst on the other master waits, with arready=0 and no loss, until the burst returns to IDLE.

Test Plan:
- Single request: m0 arvalid with araddr=0x80000000, arlen=0 → grant=01 one cycle later; s_araddr=0x80000000; one beat rdata=0x1122334455667788 with rlast → returned to m0, grant=00, protocol_err=0.
- Simultaneous request: m0 and m1 assert together, back-to-back → m0 served first; m1 next; then with both asserting again, m0 is served (alternation).
- Burst lock: m1 issues arlen=3; m0 requests during beat 2 → m0 arready stays 0 until m1's 4th beat with rlast; m0 is granted the following cycle.
- Beat mismatch: arlen=3, slave asserts rlast on beat 2 → burst ends, protocol_err=1 and stays 1.
- Stall: WDOG_W=4, slave holds s_arready=0 for 20 cycles → protocol_err=1 at 15 idle cycles; the AR later completes normally.
- Reset mid-burst: rst low during beat 1 of arlen=7 → grant=00, s_rready=0, state IDLE immediately; a new m0 request after release is granted normally.

Source files
------------

// File: rtl/axi_rd_rr_arbiter_if.sv
// One AXI4 read channel (AR + R) between a master and a slave.
// The master modport drives the request side, the slave modport answers it.
interface axi_rd_rr_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64
) ();
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rlast;
    logic              rready;

    modport master (
        output araddr, arvalid, arlen, arsize, arburst, rready,
        input  arready, rdata, rresp, rvalid, rlast
    );

    modport slave (
        input  araddr, arvalid, arlen, arsize, arburst, rready,
        output arready, rdata, rresp, rvalid, rlast
    );
endinterface

// File: rtl/axi_rd_rr_arbiter.sv
// Two-master, one-slave AXI4 read arbiter.
// m0 = instruction fetch, m1 = load/store read. The grant is round-robin
// (or fixed to m1 on ties when PRIO_M1=1) and is held from the AR
// handshake through the R beat carrying rlast. Each burst's beat count is
// checked against arlen, and a watchdog flags a stalled transaction.
// Both beat errors and watchdog saturation raise a sticky protocol_err.
module axi_rd_rr_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 64,
    parameter bit          PRIO_M1 = 1'b0,
    parameter int unsigned WDOG_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    axi_rd_rr_arbiter_if.slave         m0,
    axi_rd_rr_arbiter_if.slave         m1,
    axi_rd_rr_arbiter_if.master        s,
    output logic [1:0]                 grant,
    output logic                       protocol_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t            state;
    logic              last;       // index of the master served most recently
    logic [7:0]        beat_cnt;   // beats still expected after the current one
    logic [WDOG_W-1:0] wdog;

    // Fields of the currently granted master
    logic [ADDR_W-1:0] g_araddr;
    logic              g_arvalid;
    logic [7:0]        g_arlen;
    logic [2:0]        g_arsize;
    logic [1:0]        g_arburst;
    logic              g_rready;

    logic              pick1;
    logic              ar_hs;
    logic              r_hs;
    logic [WDOG_W-1:0] wdog_inc;
    logic [7:0]        beat_dec;

    // Select the request fields of the granted master
    always_comb begin
        if (grant[1]) begin
            g_araddr  = m1.araddr;
            g_arvalid = m1.arvalid;
            g_arlen   = m1.arlen;
            g_arsize  = m1.arsize;
            g_arburst = m1.arburst;
            g_rready  = m1.rready;
        end else begin
            g_araddr  = m0.araddr;
            g_arvalid = m0.arvalid;
            g_arlen   = m0.arlen;
            g_arsize  = m0.arsize;
            g_arburst = m0.arburst;
            g_rready  = m0.rready;
        end
    end

    // Arbitration: on a tie the master not served last wins, unless m1 has fixed priority
    always_comb begin
        if (m0.arvalid && m1.arvalid) begin
            pick1 = PRIO_M1 ? 1'b1 : ~last;
        end else begin
            pick1 = m1.arvalid;
        end
    end

    // Handshake detection and saturating counter arithmetic
    always_comb begin
        ar_hs    = (state == ADDR) && g_arvalid && s.arready;
        r_hs     = (state == DATA) && s.rvalid && g_rready;
        wdog_inc = (wdog == '1) ? wdog : wdog + WDOG_W'(1);
        beat_dec = (beat_cnt == 8'd0) ? 8'd0 : beat_cnt - 8'd1;
    end

    // Route AR to the slave in ADDR and R back to the owner in DATA; everything else idles at zero
    always_comb begin
        s.araddr   = '0;
        s.arvalid  = 1'b0;
        s.arlen    = '0;
        s.arsize   = '0;
        s.arburst  = '0;
        s.rready   = 1'b0;

        m0.arready = 1'b0;
        m0.rdata   = '0;
        m0.rresp   = '0;
        m0.rvalid  = 1'b0;
        m0.rlast   = 1'b0;

        m1.arready = 1'b0;
        m1.rdata   = '0;
        m1.rresp   = '0;
        m1.rvalid  = 1'b0;
        m1.rlast   = 1'b0;

        if (state == ADDR) begin
            s.araddr   = g_araddr;
            s.arvalid  = g_arvalid;
            s.arlen    = g_arlen;
            s.arsize   = g_arsize;
            s.arburst  = g_arburst;
            m0.arready = grant[0] & s.arready;
            m1.arready = grant[1] & s.arready;
        end

        if (state == DATA) begin
            s.rready = g_rready;
            if (grant[1]) begin
                m1.rdata  = s.rdata;
                m1.rresp  = s.rresp;
                m1.rvalid = s.rvalid;
                m1.rlast  = s.rlast;
            end else begin
                m0.rdata  = s.rdata;
                m0.rresp  = s.rresp;
                m0.rvalid = s.rvalid;
                m0.rlast  = s.rlast;
            end
        end
    end

    // Grant FSM with beat checking and watchdog; reset aborts any burst in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            grant        <= 2'b00;
            last         <= 1'b1;
            beat_cnt     <= '0;
            wdog         <= '0;
            protocol_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wdog <= '0;
                    if (m0.arvalid || m1.arvalid) begin
                        grant <= pick1 ? 2'b10 : 2'b01;
                        state <= ADDR;
                    end
                end

                ADDR: begin
                    if (ar_hs) begin
                        beat_cnt <= g_arlen;
                        wdog     <= '0;
                        state    <= DATA;
                    end else begin
                        wdog <= wdog_inc;
                        if (wdog_inc == '1) begin
                            protocol_err <= 1'b1;
                        end
                    end
                end

                DATA: begin
                    if (r_hs) begin
                        beat_cnt <= beat_dec;
                        wdog     <= '0;
                        if (s.rlast && (beat_cnt != 8'd0)) begin
                            protocol_err <= 1'b1;
                        end
                        if (!s.rlast && (beat_cnt == 8'd0)) begin
                            protocol_err <= 1'b1;
                        end
                        if (s.rlast) begin
                            last  <= grant[1];
                            grant <= 2'b00;
                            state <= IDLE;
                        end
                    end else begin
                        wdog <= wdog_inc;
                        if (wdog_inc == '1) begin
                            protocol_err <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    grant <= 2'b00;
                    wdog  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_rr_arbiter.sv
// Directed bench for axi_rd_rr_arbiter: reset, single transfer, alternation,
// burst lock, beat mismatch, reset mid-burst, watchdog stall, beat overrun.
module tb_axi_rd_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] grant;
    logic       protocol_err;

    int errors = 0;
    int checks = 0;

    axi_rd_rr_arbiter_if #(.ADDR_W(32), .DATA_W(64)) m0_if ();
    axi_rd_rr_arbiter_if #(.ADDR_W(32), .DATA_W(64)) m1_if ();
    axi_rd_rr_arbiter_if #(.ADDR_W(32), .DATA_W(64)) s_if ();

    axi_rd_rr_arbiter #(
        .ADDR_W (32),
        .DATA_W (64),
        .PRIO_M1(1'b0),
        .WDOG_W (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .m0          (m0_if),
        .m1          (m1_if),
        .s           (s_if),
        .grant       (grant),
        .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int m, input logic v, input logic [31:0] a, input logic [7:0] len);
        if (m == 0) begin
            m0_if.arvalid = v; m0_if.araddr = a; m0_if.arlen = len;
        end else begin
            m1_if.arvalid = v; m1_if.araddr = a; m1_if.arlen = len;
        end
    endtask

    task automatic drive_beat(input logic v, input logic [63:0] d, input logic l);
        s_if.rvalid = v; s_if.rdata = d; s_if.rlast = l; s_if.rresp = 2'b00;
    endtask

    task automatic test_reset();
        set_req(0, 1'b1, 32'hDEAD_0000, 8'd0);
        step(); step();
        if (grant !== 2'b00) begin errors++; $display("FAIL rst_grant: got %b exp 00", grant); end checks++;
        if (protocol_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b exp 0", protocol_err); end checks++;
        if (s_if.arvalid !== 1'b0) begin errors++; $display("FAIL rst_s_arvalid: got %b exp 0", s_if.arvalid); end checks++;
        if (s_if.rready !== 1'b0) begin errors++; $display("FAIL rst_s_rready: got %b exp 0", s_if.rready); end checks++;
        if (m0_if.arready !== 1'b0) begin errors++; $display("FAIL rst_m0_arready: got %b exp 0", m0_if.arready); end checks++;
        if (s_if.araddr !== 32'h0) begin errors++; $display("FAIL rst_s_araddr: got %h exp 0", s_if.araddr); end checks++;
        set_req(0, 1'b0, 32'h0, 8'd0);
        rst = 1'b1;
        step();
        if (grant !== 2'b00) begin errors++; $display("FAIL rst_idle_grant: got %b exp 00", grant); end checks++;
    endtask

    task automatic test_simultaneous();
        set_req(0, 1'b1, 32'h0000_0100, 8'd0);
        set_req(1, 1'b1, 32'h0000_0200, 8'd0);
        step();
        if (grant !== 2'b01) begin errors++; $display("FAIL sim1_grant: got %b exp 01", grant); end checks++;
        if (s_if.araddr !== 32'h100) begin errors++; $display("FAIL sim1_araddr: got %h exp 100", s_if.araddr); end checks++;
        if (m1_if.arready !== 1'b0) begin errors++; $display("FAIL sim1_m1_arready: got %b exp 0", m1_if.arready); end checks++;
        step();
        set_req(0, 1'b0, 32'h0, 8'd0);
        drive_beat(1'b1, 64'hA, 1'b1);
        step();
        drive_beat(1'b0, 64'h0, 1'b0);
        if (grant !== 2'b00) begin errors++; $display("FAIL sim1_end_grant: got %b exp 00", grant); end checks++;
        step();
        if (grant !== 2'b10) begin errors++; $display("FAIL sim2_grant: got %b exp 10", grant); end checks++;
        if (s_if.araddr !== 32'h200) begin errors++; $display("FAIL sim2_araddr: got %h exp 200", s_if.araddr); end checks++;
        step();
        set_req(1, 1'b0, 32'h0, 8'd0);
        drive_beat(1'b1, 64'hB, 1'b1);
        step();
        drive_beat(1'b0, 64'h0, 1'b0);
        set_req(0, 1'b1, 32'h0000_0300, 8'd0);
        set_req(1, 1'b1, 32'h0000_0400, 8'd0);
        step();
        if (grant !== 2'b01) begin errors++; $display("FAIL sim3_grant: got %b exp 01", grant); end checks++;
        step();
        set_req(0, 1'b0, 32'h0, 8'd0);
        drive_beat(1'b1, 64'hC, 1'b1);
        step();
        drive_beat(1'b0, 64'h0, 1'b0);
        step();
        if (grant !== 2'b10) begin errors++; $display("FAIL sim4_grant: got %b exp 10", grant); end checks++;
        step();
        set_req(1, 1'b0, 32'h0, 8'd0);
        drive_beat(1'b1, 64'hD, 1'b1);
        step();
        drive_beat(1'b0, 64'h0, 1'b0);
    endtask

    task automatic test_single();
        set_req(0, 1'b1, 32'h8000_0000, 8'd0);
        #1;
        if (s_if.arvalid !== 1'b0) begin errors++; $display("FAIL single_idle_arvalid: got %b exp 0", s_if.arvalid); end checks++;
        step();
        if (grant !== 2'b01) begin errors++; $display("FAIL single_grant: got %b exp 01", grant); end checks++;
        if (s_if.araddr !== 32'h8000_0000) begin errors++; $display("FAIL single_araddr: got %h exp 80000000", s_if.araddr); end checks++;
        if (s_if.arvalid !== 1'b1) begin errors++; $display("FAIL single_arvalid: got %b exp 1", s_if.arvalid); end checks++;
        if (s_if.arsize !== 3'd3) begin errors++; $display("FAIL single_arsize: got %0d exp 3", s_if.arsize); end checks++;
        if (s_if.arburst !== 2'd1) begin errors++; $display("FAIL single_arburst: got %0d exp 1", s_if.arburst); end checks++;
        if (m0_if.arready !== 1'b1) begin errors++; $display("FAIL single_m0_arready: got %b exp 1", m0_if.arready); end checks++;
        if (m1_if.arready !== 1'b0) begin errors++; $display("FAIL single_m1_arready: got %b exp 0", m1_if.arready); end checks++;
        step();
        set_req(0, 1'b0, 32'h0, 8'd0);
        drive_beat(1'b1, 64'h1122_3344_5566_7788, 1'b1);
        m0_if.rready = 1'b0;
        #1;
        if (s_if.rready !== 1'b0) begin errors++; $display("FAIL single_rready_low: got %b exp 0", s_if.rready); end checks++;
        m0_if.rready = 1'b1;
        #1;
        if (s_if.rready !== 1'b1) begin errors++; $display("FAIL single_rready_high: got %b exp 1", s_if.rready); end checks++;
        if (m0_if.rdata !== 64'h1122_3344_5566_7788) begin errors++; $display("FAIL single_rdata: got %h exp 1122334455667788", m0_if.rdata); end checks++;
        if (m0_if.rvalid !== 1'b1) begin errors++; $display("FAIL single_rvalid: got %b exp 1", m0_if.rvalid); end checks++;
        if (m0_if.rlast !== 1'b1) begin errors++; $display("FAIL single_rlast: got %b exp 1", m0_if.rlast); end checks++;
        if (m1_if.rvalid !== 1'b0) begin errors++; $display("FAIL single_m1_rvalid: got %b exp 0", m1_if.rvalid); end checks++;
        if (m1_if.rdata !== 64'h0) begin errors++; $display("FAIL single_m1_rdata: got %h exp 0", m1_if.rdata); end checks++;
        step();
        drive_beat(1'b0, 64'h0, 1'b0);
        if (grant !== 2'b00) begin errors++; $display("FAIL single_end_grant: got %b exp 00", grant); end checks++;
        if (protocol_err !== 1'b0) begin errors++; $display("FAIL single_err: got %b exp 0", protocol_err); end checks++;
    endtask

    task automatic test_burst_lock();
        set_req(1, 1'b1, 32'h0000_1000, 8'd3);
        step();
        if (grant !== 2'b10) begin errors++; $display("FAIL lock_grant: got %b exp 10", grant); end checks++;
        if (s_if.arburst !== 2'd2) begin errors++; $display("FAIL lock_arburst: got %0d exp 2", s_if.arburst); end checks++;
        step();
        set_req(1, 1'b0, 32'h0, 8'd0);
        drive_beat(1'b1, 64'h1, 1'b0);
        step();
        set_req(0, 1'b1, 32'h0000_2000, 8'd0);
        drive_beat(1'b1, 64'h2, 1'b0);
        #1;
        if (m0_if.arready !== 1'b0) begin errors++; $display("FAIL lock_m0_arready_b2: got %b exp 0", m0_if.arready); end checks++;
        if (m1_if.rdata !== 64'h2) begin errors++; $display("FAIL lock_m1_rdata: got %h exp 2", m1_if.rdata); end checks++;
        if (m0_if.rvalid !== 1'b0) begin errors++; $display("FAIL lock_m0_rvalid: got %b exp 0", m0_if.rvalid); end checks++;
        step();
        drive_beat(1'b1, 64'h3, 1'b0);
        step();
        drive_beat(1'b1, 64'h4, 1'b1);
        #1;
        if (m0_if.arready !== 1'b0) begin errors++; $display("FAIL lock_m0_arready_b4: got %b exp 0", m0_if.arready); end checks++;
        if (m1_if.rlast !== 1'b1) begin errors++; $display("FAIL lock_m1_rlast: got %b exp 1", m1_if.rlast); end checks++;
        step();
        drive_beat(1'b0, 64'h0, 1'b0);
        if (grant !== 2'b00) begin errors++; $display("FAIL lock_end_grant: got %b exp 00", grant); end checks++;
        step();
        if (grant !== 2'b01) begin errors++; $display("FAIL lock_m0_grant: got %b exp 01", grant); end checks++;
        if (s_if.araddr !== 32'h2000) begin errors++; $display("FAIL lock_m0_araddr: got %h exp 2000", s_if.araddr); end checks++;
        step();
        set_req(0, 1'b0, 32'h0, 8'd0);
        drive_beat(1'b1, 64'h5, 1'b1);
        step();
        drive_beat(1'b0, 64'h0, 1'b0);
        if (protocol_err !== 1'b0) begin errors++; $display("FAIL lock_err: got %b exp 0", protocol_err); end checks++;
    endtask

    task automatic test_beat_mismatch();
        set_req(0, 1'b1, 32'h0000_3000, 8'd3);
        step();
        step();
        set_req(0, 1'b0, 32'h0, 8'd0);
        drive_beat(1'b1, 64'h31, 1'b0);
        step();
        if (protocol_err !== 1'b0) begin errors++; $display("FAIL mism_err_b1: got %b exp 0", protocol_err); end checks++;
        drive_beat(1'b1, 64'h32, 1'b1);
        step();
        drive_beat(1'b0, 64'h0, 1'b0);
        if (grant !== 2'b00) begin errors++; $display("FAIL mism_grant: got %b exp 00", grant); end checks++;
        if (protocol_err !== 1'b1) begin errors++; $display("FAIL mism_err: got %b exp 1", protocol_err); end checks++;
        step(); step(); step();
        if (protocol_err !== 1'b1) begin errors++; $display("FAIL mism_err_sticky: got %b exp 1", protocol_err); end checks++;
    endtask

    task automatic test_reset_mid_burst();
        set_req(0, 1'b1, 32'h0000_4000, 8'd7);
        step();
        step();
        set_req(0, 1'b0, 32'h0, 8'd0);
        drive_beat(1'b1, 64'h55, 1'b0);
        #1;
        if (s_if.rready !== 1'b1) begin errors++; $display("FAIL rmb_rready_pre: got %b exp 1", s_if.rready); end checks++;
        rst = 1'b0;
        #1;
        if (grant !== 2'b00) begin errors++; $display("FAIL rmb_grant: got %b exp 00", grant); end checks++;
        if (s_if.rready !== 1'b0) begin errors++; $display("FAIL rmb_rready: got %b exp 0", s_if.rready); end checks++;
        if (m0_if.rvalid !== 1'b0) begin errors++; $display("FAIL rmb_m0_rvalid: got %b exp 0", m0_if.rvalid); end checks++;
        if (protocol_err !== 1'b0) begin errors++; $display("FAIL rmb_err: got %b exp 0", protocol_err); end checks++;
        drive_beat(1'b0, 64'h0, 1'b0);
        #1;
        rst = 1'b1;
        step();
        if (grant !== 2'b00) begin errors++; $display("FAIL rmb_idle: got %b exp 00", grant); end checks++;
        set_req(0, 1'b1, 32'h0000_5000, 8'd0);
        step();
        if (grant !== 2'b01) begin errors++; $display("FAIL rmb_new_grant: got %b exp 01", grant); end checks++;
        if (s_if.araddr !== 32'h5000) begin errors++; $display("FAIL rmb_new_araddr: got %h exp 5000", s_if.araddr); end checks++;
        step();
        set_req(0, 1'b0, 32'h0, 8'd0);
        drive_beat(1'b1, 64'h66, 1'b1);
        step();
        drive_beat(1'b0, 64'h0, 1'b0);
        if (grant !== 2'b00) begin errors++; $display("FAIL rmb_new_end: got %b exp 00", grant); end checks++;
    endtask

    task automatic test_stall();
        s_if.arready = 1'b0;
        set_req(1, 1'b1, 32'h0000_6000, 8'd0);
        step();
        if (grant !== 2'b10) begin errors++; $display("FAIL stall_grant: got %b exp 10", grant); end checks++;
        repeat (14) step();
        if (protocol_err !== 1'b0) begin errors++; $display("FAIL stall_err_14: got %b exp 0", protocol_err); end checks++;
        step();
        if (protocol_err !== 1'b1) begin errors++; $display("FAIL stall_err_15: got %b exp 1", protocol_err); end checks++;
        repeat (5) step();
        if (grant !== 2'b10) begin errors++; $display("FAIL stall_held: got %b exp 10", grant); end checks++;
        if (s_if.arvalid !== 1'b1) begin errors++; $display("FAIL stall_arvalid: got %b exp 1", s_if.arvalid); end checks++;
        s_if.arready = 1'b1;
        #1;
        if (m1_if.arready !== 1'b1) begin errors++; $display("FAIL stall_m1_arready: got %b exp 1", m1_if.arready); end checks++;
        step();
        set_req(1, 1'b0, 32'h0, 8'd0);
        drive_beat(1'b1, 64'h77, 1'b1);
        #1;
        if (m1_if.rdata !== 64'h77) begin errors++; $display("FAIL stall_rdata: got %h exp 77", m1_if.rdata); end checks++;
        step();
        drive_beat(1'b0, 64'h0, 1'b0);
        if (grant !== 2'b00) begin errors++; $display("FAIL stall_end_grant: got %b exp 00", grant); end checks++;
        if (protocol_err !== 1'b1) begin errors++; $display("FAIL stall_err_sticky: got %b exp 1", protocol_err); end checks++;
    endtask

    task automatic test_overrun();
        rst = 1'b0;
        #1;
        if (protocol_err !== 1'b0) begin errors++; $display("FAIL ovr_rst_err: got %b exp 0", protocol_err); end checks++;
        rst = 1'b1;
        set_req(0, 1'b1, 32'h0000_7000, 8'd0);
        step();
        if (grant !== 2'b01) begin errors++; $display("FAIL ovr_grant: got %b exp 01", grant); end checks++;
        step();
        set_req(0, 1'b0, 32'h0, 8'd0);
        drive_beat(1'b1, 64'h1, 1'b0);
        step();
        if (protocol_err !== 1'b1) begin errors++; $display("FAIL ovr_err: got %b exp 1", protocol_err); end checks++;
        if (grant !== 2'b01) begin errors++; $display("FAIL ovr_still_granted: got %b exp 01", grant); end checks++;
        drive_beat(1'b1, 64'h2, 1'b1);
        step();
        drive_beat(1'b0, 64'h0, 1'b0);
        if (grant !== 2'b00) begin errors++; $display("FAIL ovr_end_grant: got %b exp 00", grant); end checks++;
    endtask

    initial begin
        m0_if.arvalid = 1'b0; m0_if.araddr = '0; m0_if.arlen = '0;
        m0_if.arsize = 3'd3; m0_if.arburst = 2'd1; m0_if.rready = 1'b1;
        m1_if.arvalid = 1'b0; m1_if.araddr = '0; m1_if.arlen = '0;
        m1_if.arsize = 3'd2; m1_if.arburst = 2'd2; m1_if.rready = 1'b1;
        s_if.arready = 1'b1; s_if.rvalid = 1'b0; s_if.rdata = '0;
        s_if.rresp = 2'b00; s_if.rlast = 1'b0;
        #2;
        rst = 1'b0;
        test_reset();
        test_simultaneous();
        test_single();
        test_burst_lock();
        test_beat_mismatch();
        test_reset_mid_burst();
        test_stall();
        test_overrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
